// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared CPU constants: fetch FSM encoding, decoder opcodes, branch offset helper
package instruction_fetch_unit_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] IFU_IDLE  = 2'd0;
    localparam logic [1:0] IFU_REQ   = 2'd1;
    localparam logic [1:0] IFU_HOLD  = 2'd2;
    localparam logic [1:0] IFU_FAULT = 2'd3;

    // Decoder opcode / function constants shared with the decode stage
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    // Word-scaled, sign-extended branch displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_logic.sv
// rtl/instruction_fetch_unit_next_pc_logic.sv - combinational next-PC selection with misalignment flag
module next_pc_logic
    import instruction_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        inv_zero,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // Priority: jr, then j/jal, then taken branch, else fall through; all adds wrap mod 2^32
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_index, 2'b00};
        end else if (branch && (zero ^ inv_zero)) begin
            next_pc = pc_plus4 + branch_offset(instr_index[15:0]);
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch FSM: request, hold instruction for decode, redirect on completion
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        InvZero,
    input  logic        Zero,
    input  logic [31:0] jr_target,
    output logic        fault
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        next_misaligned;

    // pc is the fetch address while requesting and equals pc_out while holding
    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign imem_req    = (state == IFU_REQ);
    assign instr_valid = (state == IFU_HOLD);
    assign fault       = (state == IFU_FAULT);

    next_pc_logic u_next_pc_logic (
        .pc_plus4    (pc_plus4),
        .instr_index (instruction[25:0]),
        .jr_target   (jr_target),
        .branch      (Branch),
        .jump        (Jump),
        .jump_reg    (JumpReg),
        .inv_zero    (InvZero),
        .zero        (Zero),
        .next_pc     (next_pc),
        .misaligned  (next_misaligned)
    );

    // FSM and fetch registers; ack only matters in REQ, exec_done only in HOLD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IFU_IDLE;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            pc_out      <= 32'h0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    pc    <= RESET_PC;
                    state <= IFU_REQ;
                end
                IFU_REQ: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        pc_out      <= pc;
                        state       <= IFU_HOLD;
                    end
                end
                IFU_HOLD: begin
                    if (exec_done) begin
                        if (next_misaligned) begin
                            state <= IFU_FAULT;
                        end else begin
                            pc    <= next_pc;
                            state <= IFU_REQ;
                        end
                    end
                end
                IFU_FAULT: begin
                    state <= IFU_FAULT;
                end
                default: begin
                    state <= IFU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic        InvZero;
    logic        Zero;
    logic [31:0] jr_target;
    logic        fault;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .exec_done   (exec_done),
        .Branch      (Branch),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .InvZero     (InvZero),
        .Zero        (Zero),
        .jr_target   (jr_target),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        exec_done = 1'b0;
        Branch    = 1'b0;
        Jump      = 1'b0;
        JumpReg   = 1'b0;
        InvZero   = 1'b0;
        Zero      = 1'b0;
    endtask

    // One exec_done cycle with the given flags (b, j, jr, iz, z)
    task automatic retire(input logic b, input logic j, input logic jr, input logic iz, input logic z);
        Branch    = b;
        Jump      = j;
        JumpReg   = jr;
        InvZero   = iz;
        Zero      = z;
        exec_done = 1'b1;
        step();
        clear_flags();
    endtask

    task automatic ack_fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
    endtask

    // From HOLD, redirect with jr and complete the fetch: ends in HOLD at target
    task automatic go_to(input logic [31:0] target, input logic [31:0] word);
        jr_target = target;
        retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ack_fetch(word);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req got %b want 0", imem_req); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid got %b want 0", instr_valid); else pass_cnt++;
        total_cnt++; if (fault !== 1'b0) $display("FAIL rst_fault got %b want 0", fault); else pass_cnt++;
        total_cnt++; if (pc_out !== 32'h0) $display("FAIL rst_pc_out got %h want 00000000", pc_out); else pass_cnt++;
        total_cnt++; if (instruction !== 32'h0) $display("FAIL rst_instruction got %h want 00000000", instruction); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL rst_imem_addr got %h want 00000000", imem_addr); else pass_cnt++;
        total_cnt++; if (pc_plus4 !== 32'h4) $display("FAIL rst_pc_plus4 got %h want 00000004", pc_plus4); else pass_cnt++;
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else pass_cnt++;
        step();
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL first_req got %b want 1", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL first_addr got %h want 00000000", imem_addr); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL first_valid_early got %b want 0", instr_valid); else pass_cnt++;
        ack_fetch(32'h2008_0005);
        total_cnt++; if (instr_valid !== 1'b1) $display("FAIL first_valid got %b want 1", instr_valid); else pass_cnt++;
        total_cnt++; if (instruction !== 32'h2008_0005) $display("FAIL first_instr got %h want 20080005", instruction); else pass_cnt++;
        total_cnt++; if (pc_out !== 32'h0) $display("FAIL first_pc_out got %h want 00000000", pc_out); else pass_cnt++;
        total_cnt++; if (pc_plus4 !== 32'h4) $display("FAIL first_pc_plus4 got %h want 00000004", pc_plus4); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL hold_req got %b want 0", imem_req); else pass_cnt++;
    endtask

    task automatic test_sequential();
        go_to(32'h0000_0008, 32'h0000_0020);
        total_cnt++; if (pc_out !== 32'h8) $display("FAIL seq_pc_out got %h want 00000008", pc_out); else pass_cnt++;
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'hC) $display("FAIL seq_addr got %h want 0000000c", imem_addr); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL seq_req got %b want 1", imem_req); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL seq_valid_drop got %b want 0", instr_valid); else pass_cnt++;
        ack_fetch(32'h0);
    endtask

    task automatic test_branch();
        go_to(32'h0000_0010, 32'h1000_FFFE);
        retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        total_cnt++; if (imem_addr !== 32'hC) $display("FAIL beq_taken got %h want 0000000c", imem_addr); else pass_cnt++;
        ack_fetch(32'h0);
        go_to(32'h0000_0010, 32'h1400_FFFE);
        retire(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        total_cnt++; if (imem_addr !== 32'h14) $display("FAIL bne_not_taken got %h want 00000014", imem_addr); else pass_cnt++;
        ack_fetch(32'h0);
        go_to(32'h0000_0010, 32'h1400_FFFE);
        retire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (imem_addr !== 32'hC) $display("FAIL bne_taken got %h want 0000000c", imem_addr); else pass_cnt++;
        ack_fetch(32'h0);
    endtask

    task automatic test_jump();
        go_to(32'h0000_0040, 32'h0C00_0009);
        total_cnt++; if (pc_plus4 !== 32'h44) $display("FAIL jal_link got %h want 00000044", pc_plus4); else pass_cnt++;
        retire(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'h24) $display("FAIL jal_target got %h want 00000024", imem_addr); else pass_cnt++;
        ack_fetch(32'h0);
        go_to(32'h0000_0040, 32'h0C00_0009);
        retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        total_cnt++; if (imem_addr !== 32'h24) $display("FAIL jump_over_branch got %h want 00000024", imem_addr); else pass_cnt++;
        ack_fetch(32'h0);
        go_to(32'h0000_0040, 32'h0C00_0009);
        jr_target = 32'h0000_0100;
        retire(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'h100) $display("FAIL jr_target got %h want 00000100", imem_addr); else pass_cnt++;
        ack_fetch(32'h0);
    endtask

    task automatic test_stall();
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        jr_target = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            exec_done = 1'b1;
            JumpReg   = 1'b1;
            step();
            total_cnt++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0104})
                $display("FAIL stall_cycle%0d got req=%b addr=%h want req=1 addr=00000104", i, imem_req, imem_addr);
            else pass_cnt++;
        end
        clear_flags();
        ack_fetch(32'hAAAA_0001);
        total_cnt++; if (pc_out !== 32'h104) $display("FAIL stall_pc_out got %h want 00000104", pc_out); else pass_cnt++;
        total_cnt++; if (instruction !== 32'hAAAA_0001) $display("FAIL stall_instr got %h want aaaa0001", instruction); else pass_cnt++;
        ack_fetch(32'hDEAD_BEEF);
        total_cnt++; if (instruction !== 32'hAAAA_0001) $display("FAIL hold_ack_ignored got %h want aaaa0001", instruction); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b1) $display("FAIL hold_still_valid got %b want 1", instr_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_req();
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL midreq_rst_req got %b want 0", imem_req); else pass_cnt++;
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack   = 1'b0;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL late_ack_valid got %b want 0", instr_valid); else pass_cnt++;
        total_cnt++; if (instruction !== 32'h0) $display("FAIL late_ack_instr got %h want 00000000", instruction); else pass_cnt++;
        total_cnt++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL restart got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); else pass_cnt++;
        ack_fetch(32'h5555_0000);
        rst_n = 1'b0;
        step();
        total_cnt++; if (instruction !== 32'h0) $display("FAIL hold_rst_instr got %h want 00000000", instruction); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL hold_rst_valid got %b want 0", instr_valid); else pass_cnt++;
        rst_n = 1'b1;
        step();
        ack_fetch(32'h0);
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC, 32'h0);
        total_cnt++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4 got %h want 00000000", pc_plus4); else pass_cnt++;
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h want 00000000", imem_addr); else pass_cnt++;
        ack_fetch(32'h0);
    endtask

    task automatic test_fault();
        go_to(32'h0000_0040, 32'h0);
        jr_target = 32'h0000_0102;
        retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (fault !== 1'b1) $display("FAIL fault_set got %b want 1", fault); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL fault_req got %b want 0", imem_req); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL fault_valid got %b want 0", instr_valid); else pass_cnt++;
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if ({fault, imem_req, instr_valid} !== 3'b100)
                $display("FAIL fault_sticky%0d got fault/req/valid=%b want 100", i, {fault, imem_req, instr_valid});
            else pass_cnt++;
        end
        imem_ack = 1'b0;
        clear_flags();
        rst_n = 1'b0;
        step();
        total_cnt++; if (fault !== 1'b0) $display("FAIL fault_clear got %b want 0", fault); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        jr_target  = 32'h0;
        clear_flags();
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_reset_mid_req();
        test_wrap();
        test_fault();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
